// File: rtl/gumnut_pkg.sv
// Shared opcode/function encodings, instruction width and fetch FSM states
// for the instruction fetch unit.
package gumnut_pkg;

    localparam int INST_W = 18;

    localparam logic [2:0] OP_BRANCH = 3'd5;
    localparam logic [2:0] OP_JUMP   = 3'd6;
    localparam logic [2:0] OP_MISC   = 3'd7;

    localparam logic [2:0] FN_JMP = 3'd0;
    localparam logic [2:0] FN_JSB = 3'd1;
    localparam logic [2:0] FN_RET = 3'd0;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction bus (cyc/stb/ack) between the fetch unit (master) and program memory (slave).
interface inst_fetch_unit_if #(
    parameter int PC_W = 12
);
    logic                          inst_cyc_o;
    logic                          inst_stb_o;
    logic [PC_W-1:0]               inst_adr_o;
    logic [gumnut_pkg::INST_W-1:0] inst_dat_i;
    logic                          inst_ack_i;

    modport master (
        output inst_cyc_o, inst_stb_o, inst_adr_o,
        input  inst_dat_i, inst_ack_i
    );

    modport slave (
        input  inst_cyc_o, inst_stb_o, inst_adr_o,
        output inst_dat_i, inst_ack_i
    );
endinterface

// File: rtl/inst_fetch_unit_ret_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty yields RST_VEC; both misuses raise a one-cycle error pulse.
module ret_stack #(
    parameter int              PC_W    = 12,
    parameter int              STACK_D = 8,
    parameter logic [PC_W-1:0] RST_VEC = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [PC_W-1:0]          i_data,
    output logic [PC_W-1:0]          o_data,
    output logic [$clog2(STACK_D):0] o_sp,
    output logic                     o_err
);
    localparam int PTR_W = $clog2(STACK_D);

    logic [PC_W-1:0]  r_mem [STACK_D];
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W:0]   r_sp;
    logic             r_err;
    logic [PTR_W-1:0] w_top_idx;
    logic             w_full;
    logic             w_empty;

    // r_ptr is the next write slot; it wraps freely so overflow overwrites the oldest entry
    assign w_top_idx = r_ptr - PTR_W'(1);
    assign w_full    = (r_sp == (PTR_W+1)'(STACK_D));
    assign w_empty   = (r_sp == '0);
    assign o_data    = w_empty ? RST_VEC : r_mem[w_top_idx];
    assign o_sp      = r_sp;
    assign o_err     = r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
            r_sp  <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= (i_push && w_full) || (i_pop && w_empty);
            if (i_push) begin
                r_mem[r_ptr] <= i_data;
                r_ptr        <= r_ptr + PTR_W'(1);
                if (!w_full) begin
                    r_sp <= r_sp + (PTR_W+1)'(1);
                end
            end else if (i_pop && !w_empty) begin
                r_ptr <= w_top_idx;
                r_sp  <= r_sp - (PTR_W+1)'(1);
            end
        end
    end
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words into the IR over the
// instruction bus and resolves the next PC (branch/jump/jsb/ret) on retirement.
module inst_fetch_unit
    import gumnut_pkg::*;
#(
    parameter int              PC_W    = 12,
    parameter int              STACK_D = 8,
    parameter logic [PC_W-1:0] RST_VEC = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    inst_fetch_unit_if.master   bus,
    output logic [INST_W-1:0]   ir_o,
    output logic                ir_valid_o,
    output logic [PC_W-1:0]     pc_o,
    input  logic                exec_done_i,
    input  logic [2:0]          op_e,
    input  logic [2:0]          func_e,
    input  logic [PC_W-1:0]     addr_e,
    input  logic [7:0]          disp_e,
    input  logic                carry_e,
    input  logic                zero_e,
    output logic                stack_err_o
);
    fetch_state_t          r_state;
    fetch_state_t          w_state_next;
    logic [PC_W-1:0]       r_pc;
    logic [INST_W-1:0]     r_ir;
    logic                  r_ir_valid;
    logic [PC_W-1:0]       w_next_pc;
    logic [PC_W-1:0]       w_pc_inc;
    logic [PC_W-1:0]       w_pop_data;
    logic [$clog2(STACK_D):0] w_sp;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_taken;
    logic                  w_fetch;
    logic                  w_retire;

    assign w_fetch  = (r_state == FETCH);
    assign w_retire = (r_state == EXEC) && exec_done_i;
    assign w_pc_inc = r_pc + PC_W'(1);

    assign bus.inst_cyc_o = w_fetch;
    assign bus.inst_stb_o = w_fetch;
    assign bus.inst_adr_o = r_pc;
    assign ir_o           = r_ir;
    assign ir_valid_o     = r_ir_valid;
    assign pc_o           = r_pc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RESET:   w_state_next = FETCH;
            FETCH:   if (bus.inst_ack_i) w_state_next = EXEC;
            EXEC:    if (exec_done_i)    w_state_next = FETCH;
            default: w_state_next = RESET;
        endcase
    end

    // Stack operations are qualified by w_retire so each instruction touches the stack once
    always_comb begin
        w_next_pc = w_pc_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_taken   = 1'b0;
        case (func_e[1:0])
            2'b00: w_taken = zero_e;
            2'b01: w_taken = !zero_e;
            2'b10: w_taken = carry_e;
            2'b11: w_taken = !carry_e;
            default: w_taken = 1'b0;
        endcase
        case (op_e)
            OP_BRANCH: begin
                if (w_taken) w_next_pc = w_pc_inc + {{(PC_W-8){disp_e[7]}}, disp_e};
            end
            OP_JUMP: begin
                if (func_e == FN_JMP) begin
                    w_next_pc = addr_e;
                end else if (func_e == FN_JSB) begin
                    w_next_pc = addr_e;
                    w_push    = w_retire;
                end
            end
            OP_MISC: begin
                if (func_e == FN_RET) begin
                    w_next_pc = w_pop_data;
                    w_pop     = w_retire;
                end
            end
            default: w_next_pc = w_pc_inc;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc       <= RST_VEC;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else if (w_fetch && bus.inst_ack_i) begin
            r_ir       <= bus.inst_dat_i;
            r_ir_valid <= 1'b1;
        end else if (w_retire) begin
            r_pc       <= w_next_pc;
            r_ir_valid <= 1'b0;
        end
    end

    ret_stack #(
        .PC_W    (PC_W),
        .STACK_D (STACK_D),
        .RST_VEC (RST_VEC)
    ) u_stack (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_data (w_pc_inc),
        .o_data (w_pop_data),
        .o_sp   (w_sp),
        .o_err  (stack_err_o)
    );
endmodule
